// File: rtl/g_3arb_rr.sv
// g_3arb_rr: three-requester round-robin arbiter with active-low requests
// and one-hot active-low grants. A one-cycle all-high grant gap separates
// owners. A grant held for MAXHOLD cycles is forcibly released when another
// requester is waiting.
// Optional feature macro: G_3ARB_LOCK_EN adds the active-low LOCKN input,
// which holds off forced release while low during a grant.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no owner; GN all high; next edge grants the first requester
//         | after the last owner in round-robin order
// S_GRANT | GN[GIDX] low; CNT counts held cycles; leaves on owner release
//         | or on forced release (TOUT pulse)
module g_3arb_rr #(
   parameter int MAXHOLD = 8,
   parameter int CW      = 4
) (
   input  logic       CK,
   input  logic       CD,
   input  logic [2:0] RN,
`ifdef G_3ARB_LOCK_EN
   input  logic       LOCKN,
`endif
   output logic [2:0] GN,
   output logic       VLD,
   output logic [1:0] GIDX,
   output logic       TOUT
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   // CNT value at which the grant has been held MAXHOLD cycles
   localparam logic [CW-1:0] HOLD_LAST = (MAXHOLD == 0) ? '0 : CW'(MAXHOLD - 1);
   localparam bit            HOLD_EN   = (MAXHOLD != 0);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    gn_nxt;
   logic          vld_nxt;
   logic [1:0]    gidx_nxt;
   logic          tout_nxt;

   logic [2:0]    req;
   logic [1:0]    p0, p1, p2;
   logic [1:0]    sel;
   logic          sel_vld;
   logic          own_req;
   logic          others_req;
   logic          lock;
   logic          do_force;

   // request decode: only a solid 0 counts, so X/Z reads as deasserted
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         req[i] = (RN[i] === 1'b0);
      end
   end

`ifdef G_3ARB_LOCK_EN
   // lock qualifier, only meaningful while a grant is held
   always_comb begin
      lock = (LOCKN === 1'b0);
   end
`else
   // without the lock option the arbiter is permanently unlocked
   always_comb begin
      lock = 1'b0;
   end
`endif

   // round-robin search order starts just after the last owner
   always_comb begin
      case (GIDX)
         2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
         2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
         default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
      endcase
      sel_vld = |req;
      if (req[p0])      sel = p0;
      else if (req[p1]) sel = p1;
      else              sel = p2;
   end

   // owner / competitor status and forced-release decision
   always_comb begin
      case (GIDX)
         2'd0:    begin own_req = req[0]; others_req = req[1] | req[2]; end
         2'd1:    begin own_req = req[1]; others_req = req[0] | req[2]; end
         default: begin own_req = req[2]; others_req = req[0] | req[1]; end
      endcase
      do_force = HOLD_EN && (cnt >= HOLD_LAST) && others_req && own_req && !lock;
   end

   // state register plus registered outputs; reset wins over everything
   always_ff @(posedge CK) begin
      if (CD) begin
         state <= S_IDLE;
         cnt   <= '0;
         GN    <= 3'b111;
         VLD   <= 1'b0;
         GIDX  <= 2'd2;
         TOUT  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         GN    <= gn_nxt;
         VLD   <= vld_nxt;
         GIDX  <= gidx_nxt;
         TOUT  <= tout_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (sel_vld) state_nxt = S_GRANT;
         S_GRANT: if (!own_req || do_force) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // next values of the registered outputs and hold counter
   always_comb begin
      gn_nxt   = GN;
      vld_nxt  = VLD;
      gidx_nxt = GIDX;
      tout_nxt = 1'b0;
      cnt_nxt  = cnt;
      case (state)
         S_IDLE: begin
            if (sel_vld) begin
               gn_nxt   = ~(3'b001 << sel);
               vld_nxt  = 1'b1;
               gidx_nxt = sel;
               cnt_nxt  = '0;
            end else begin
               gn_nxt  = 3'b111;
               vld_nxt = 1'b0;
            end
         end
         S_GRANT: begin
            cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
            if (!own_req) begin
               gn_nxt  = 3'b111;
               vld_nxt = 1'b0;
            end else if (do_force) begin
               gn_nxt   = 3'b111;
               vld_nxt  = 1'b0;
               tout_nxt = 1'b1;
            end
         end
         default: begin
            gn_nxt  = 3'b111;
            vld_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_g_3arb_rr.sv
// tb_g_3arb_rr: directed scenarios plus randomized traffic for g_3arb_rr,
// checked against a cycle-level ownership model (owner, last owner, cycles held).
module tb_g_3arb_rr;

   localparam int MAXHOLD = 8;
   localparam int CW      = 4;

   logic       CK;
   logic       CD;
   logic [2:0] RN;
   logic       lockn;
   logic [2:0] GN;
   logic       VLD;
   logic [1:0] GIDX;
   logic       TOUT;

   int checks   = 0;
   int failures = 0;

   // model state
   int m_owner;   // -1 when nobody holds the grant
   int m_last;
   int m_held;    // cycles the current owner has been granted
   bit m_tout;

   g_3arb_rr #(.MAXHOLD(MAXHOLD), .CW(CW)) dut (
      .CK   (CK),
      .CD   (CD),
      .RN   (RN),
`ifdef G_3ARB_LOCK_EN
      .LOCKN(lockn),
`endif
      .GN   (GN),
      .VLD  (VLD),
      .GIDX (GIDX),
      .TOUT (TOUT)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic [2:0] rn_i, input logic cd_i, input logic lockn_i);
      bit locked;
      bit others;
`ifdef G_3ARB_LOCK_EN
      locked = (lockn_i == 1'b0);
`else
      locked = 1'b0;
      if (lockn_i) locked = 1'b0;
`endif
      if (cd_i) begin
         m_owner = -1;
         m_last  = 2;
         m_held  = 0;
         m_tout  = 0;
      end else if (m_owner < 0) begin
         m_tout = 0;
         for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (m_last + k) % 3;
            if (m_owner < 0 && rn_i[idx] == 1'b0) begin
               m_owner = idx;
               m_last  = idx;
               m_held  = 1;
            end
         end
      end else begin
         m_tout = 0;
         others = 0;
         for (int k = 0; k < 3; k++)
            if (k != m_owner && rn_i[k] == 1'b0) others = 1;
         if (rn_i[m_owner] == 1'b1) begin
            m_owner = -1;
         end else if (MAXHOLD > 0 && m_held >= MAXHOLD && others && !locked) begin
            m_owner = -1;
            m_tout  = 1;
         end else begin
            m_held++;
         end
      end
   endtask

   // drive one cycle of inputs, advance one edge, compare DUT with model
   task automatic step(input logic [2:0] rn_i, input logic cd_i);
      logic [2:0] exp_gn;
      RN = rn_i;
      CD = cd_i;
      @(posedge CK);
      #1;
      model_edge(rn_i, cd_i, lockn);
      exp_gn = (m_owner < 0) ? 3'b111 : ~(3'b001 << m_owner);
      chk("gn",   GN,   exp_gn);
      chk("vld",  VLD,  (m_owner >= 0));
      chk("gidx", GIDX, m_last[1:0]);
      chk("tout", TOUT, m_tout);
      chk("gn_onehot", ($countones(~GN) <= 1), 1'b1);
   endtask

   logic [2:0] seq[$];
   logic [2:0] rv[$];
   int         rl[$];
   logic [2:0] ev[7];
   int         el[6];
   int         cnt_a;
   int         cnt_b;

   initial begin
      RN    = 3'b111;
      CD    = 1'b1;
      lockn = 1'b1;
      m_owner = -1; m_last = 2; m_held = 0; m_tout = 0;

      // reset state
      step(3'b111, 1'b1);
      step(3'b111, 1'b1);
      chk("rst_gn",   GN,   3'b111);
      chk("rst_gidx", GIDX, 2'd2);

      // single request and release
      step(3'b110, 1'b0);
      chk("req0_gn",   GN,   3'b110);
      chk("req0_gidx", GIDX, 2'd0);
      step(3'b111, 1'b0);
      chk("rel0_gn",   GN,   3'b111);
      chk("rel0_gidx", GIDX, 2'd0);

      // all requesting: forced rotation with single-cycle gaps
      step(3'b111, 1'b1);
      seq.delete();
      cnt_a = 0;
      for (int i = 0; i < 28; i++) begin
         step(3'b000, 1'b0);
         seq.push_back(GN);
         if (TOUT) cnt_a++;
      end
      rv.delete(); rl.delete();
      foreach (seq[i]) begin
         if (i == 0 || seq[i] != seq[i-1]) begin
            rv.push_back(seq[i]);
            rl.push_back(1);
         end else begin
            rl[rl.size()-1]++;
         end
      end
      ev = '{3'b110, 3'b111, 3'b101, 3'b111, 3'b011, 3'b111, 3'b110};
      el = '{8, 1, 8, 1, 8, 1};
      chk("rot_nruns", (rv.size() >= 7), 1'b1);
      for (int i = 0; i < 7; i++) begin
         if (i < rv.size()) begin
            chk("rot_val", rv[i], ev[i]);
            if (i < 6) chk("rot_len", rl[i], el[i]);
         end
      end
      chk("rot_tout_cnt", cnt_a, 3);

      // sole requester never times out
      step(3'b111, 1'b1);
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 20; i++) begin
         step(3'b101, 1'b0);
         if (GN == 3'b101) cnt_a++;
         if (TOUT) cnt_b++;
      end
      chk("sole_gn_cycles", cnt_a, 20);
      chk("sole_tout_cnt",  cnt_b, 0);

      // reset during a grant restores pointer 2
      step(3'b111, 1'b1);
      step(3'b011, 1'b0);
      chk("g2_gn", GN, 3'b011);
      step(3'b011, 1'b1);
      chk("g2_rst_gn",   GN,   3'b111);
      chk("g2_rst_gidx", GIDX, 2'd2);
      step(3'b011, 1'b0);
      chk("g2_after_rst_gn", GN, 3'b011);

      // owner release coincides with timeout: normal release
      step(3'b111, 1'b1);
      step(3'b101, 1'b0);
      chk("o1_gn", GN, 3'b101);
      for (int i = 0; i < 7; i++) step(3'b100, 1'b0);
      chk("o1_still_gn", GN, 3'b101);
      step(3'b110, 1'b0);
      chk("o1_rel_gn",   GN,   3'b111);
      chk("o1_rel_tout", TOUT, 1'b0);
      step(3'b110, 1'b0);
      chk("o1_next_gn", GN, 3'b110);

`ifdef G_3ARB_LOCK_EN
      // lock holds off forced release
      step(3'b111, 1'b1);
      lockn = 1'b0;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 30; i++) begin
         step(3'b000, 1'b0);
         if (GN == 3'b110) cnt_a++;
         if (TOUT) cnt_b++;
      end
      chk("lock_gn_cycles", cnt_a, 30);
      chk("lock_tout_cnt",  cnt_b, 0);
      lockn = 1'b1;
      step(3'b000, 1'b0);
      chk("unlock_gn",   GN,   3'b111);
      chk("unlock_tout", TOUT, 1'b1);
`endif

      // randomized traffic with sticky requests and occasional reset
      step(3'b111, 1'b1);
      begin
         logic [2:0] rn_r;
         rn_r = 3'b111;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rn_r = 3'($urandom_range(0, 7));
            lockn = ($urandom_range(0, 4) != 0);
            step(rn_r, ($urandom_range(0, 60) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
